sal_cmd_sched: RTL

SAL_CMD_SCHED -- requirements
Module: sal_cmd_sched

---
 rtl/sal_cmd_sched_pkg.sv | 38 +++
 rtl/sal_rr_arbiter.sv | 39 +++
 rtl/sal_cmd_sched.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/sal_cmd_sched_pkg.sv
// Shared DDR2 scheduler types: DFI command encodings, control-bus struct,
// address/timing widths and timer helpers.
package sal_cmd_sched_pkg;

  localparam int DRAM_RA_WIDTH  = 15;
  localparam int DRAM_CA_WIDTH  = 10;
  localparam int DFI_ADDR_WIDTH = 15;
  localparam int TIMER_WIDTH    = 4;
  localparam int T_RRD_WIDTH    = TIMER_WIDTH;
  localparam int T_CCD_WIDTH    = TIMER_WIDTH;
  localparam int T_WTR_WIDTH    = TIMER_WIDTH;
  localparam int T_RTW_WIDTH    = TIMER_WIDTH;

  // {ras_n, cas_n, we_n}
  typedef enum logic [2:0] {
    CMD_NOP = 3'b111,
    CMD_ACT = 3'b011,
    CMD_RD  = 3'b101,
    CMD_WR  = 3'b100,
    CMD_PRE = 3'b010,
    CMD_REF = 3'b001
  } dfi_cmd_e;

  typedef struct packed {
    logic [1:0]                cs_n;
    dfi_cmd_e                  cmd;
    logic [DFI_ADDR_WIDTH-1:0] addr;
  } dfi_ctl_t;

  function automatic logic [TIMER_WIDTH-1:0] timer_load(input logic [TIMER_WIDTH-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  function automatic logic [TIMER_WIDTH-1:0] timer_dec(input logic [TIMER_WIDTH-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

endpackage

// File: rtl/sal_rr_arbiter.sv
// N-way round-robin arbiter: one-hot combinational grant; the pointer moves
// to the bank after the winner only when a grant is issued.
module sal_rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_ptr_nxt;
  logic          w_found;

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    o_gnt     = '0;
    w_ptr_nxt = r_ptr;
    w_found   = 1'b0;
    for (int off = 0; off < N; off++) begin
      if (i_en && !w_found && i_req[(int'(r_ptr) + off) % N]) begin
        w_found                          = 1'b1;
        o_gnt[(int'(r_ptr) + off) % N]   = 1'b1;
        w_ptr_nxt                        = PW'((int'(r_ptr) + off + 1) % N);
      end
    end
  end

  // NOTE: clocked state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_ptr <= '0;
    else if (w_found) r_ptr <= w_ptr_nxt;
  end

endmodule

// File: rtl/sal_cmd_sched.sv
// DDR2 command scheduler: REF > CAS > ACT > PRE, round-robin per class, registered DFI bus.
// Optional ODT generation enabled by defining SAL_CMD_SCHED_ODT_EN.
module sal_cmd_sched
  import sal_cmd_sched_pkg::*;
#(
  parameter int NUM_BANKS = 4,
  parameter int ODT_LEN   = 4,
  localparam int BA_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [NUM_BANKS-1:0]                     act_req,
  input  logic [NUM_BANKS-1:0]                     rd_req,
  input  logic [NUM_BANKS-1:0]                     wr_req,
  input  logic [NUM_BANKS-1:0]                     pre_req,
  input  logic [NUM_BANKS-1:0]                     ref_req,
  input  logic [NUM_BANKS-1:0][DRAM_RA_WIDTH-1:0]  ra,
  input  logic [NUM_BANKS-1:0][DRAM_CA_WIDTH-1:0]  ca,
  output logic [NUM_BANKS-1:0]                     act_gnt,
  output logic [NUM_BANKS-1:0]                     rd_gnt,
  output logic [NUM_BANKS-1:0]                     wr_gnt,
  output logic [NUM_BANKS-1:0]                     pre_gnt,
  output logic [NUM_BANKS-1:0]                     ref_gnt,
  input  logic [T_RRD_WIDTH-1:0]                   t_rrd,
  input  logic [T_CCD_WIDTH-1:0]                   t_ccd,
  input  logic [T_WTR_WIDTH-1:0]                   t_wtr,
  input  logic [T_RTW_WIDTH-1:0]                   t_rtw,
  output logic                                     cke,
  output logic [1:0]                               cs_n,
  output logic                                     ras_n,
  output logic                                     cas_n,
  output logic                                     we_n,
  output logic [BA_W-1:0]                          ba,
  output logic [DFI_ADDR_WIDTH-1:0]                addr,
  output logic                                     odt
);

  if (ODT_LEN < 1) begin : g_odt_len_check
    $error("ODT_LEN must be at least 1");
  end

  logic                   r_cke;
  logic [T_RRD_WIDTH-1:0] r_rrd;
  logic [T_CCD_WIDTH-1:0] r_ccd;
  logic [T_WTR_WIDTH-1:0] r_wtr;
  logic [T_RTW_WIDTH-1:0] r_rtw;
  dfi_ctl_t               r_ctl;
  logic [BA_W-1:0]        r_ba;

  logic                 w_rd_ok, w_wr_ok;
  logic                 w_ref_sel, w_cas_sel, w_act_sel, w_pre_sel;
  logic [NUM_BANKS-1:0] w_rd_elig, w_cas_req, w_act_req;
  logic [NUM_BANKS-1:0] w_cas_gnt, w_act_gnt, w_pre_gnt;
  logic [BA_W-1:0]      w_bank;
  dfi_ctl_t             w_ctl;
  logic [BA_W-1:0]      w_ba;

  // r_cke doubles as the "first cycle after reset is over" qualifier for grants.
  assign w_rd_ok   = (r_ccd == '0) && (r_wtr == '0);
  assign w_wr_ok   = (r_ccd == '0) && (r_rtw == '0);
  assign w_rd_elig = rd_req & {NUM_BANKS{w_rd_ok}};
  assign w_cas_req = w_rd_elig | (wr_req & {NUM_BANKS{w_wr_ok}});
  assign w_act_req = act_req & {NUM_BANKS{r_rrd == '0}};

  assign w_ref_sel = r_cke & (&ref_req);
  assign w_cas_sel = r_cke & ~w_ref_sel & (|w_cas_req);
  assign w_act_sel = r_cke & ~w_ref_sel & ~(|w_cas_req) & (|w_act_req);
  assign w_pre_sel = r_cke & ~w_ref_sel & ~(|w_cas_req) & ~(|w_act_req) & (|pre_req);

  sal_rr_arbiter #(.N(NUM_BANKS)) u_cas_arb (
    .clk(clk), .rst_n(rst_n), .i_en(w_cas_sel), .i_req(w_cas_req), .o_gnt(w_cas_gnt));
  sal_rr_arbiter #(.N(NUM_BANKS)) u_act_arb (
    .clk(clk), .rst_n(rst_n), .i_en(w_act_sel), .i_req(w_act_req), .o_gnt(w_act_gnt));
  sal_rr_arbiter #(.N(NUM_BANKS)) u_pre_arb (
    .clk(clk), .rst_n(rst_n), .i_en(w_pre_sel), .i_req(pre_req), .o_gnt(w_pre_gnt));

  // A bank asking for both RD and WR with both eligible is served RD first.
  assign rd_gnt  = w_cas_gnt & w_rd_elig;
  assign wr_gnt  = w_cas_gnt & ~w_rd_elig;
  assign act_gnt = w_act_gnt;
  assign pre_gnt = w_pre_gnt;
  assign ref_gnt = {NUM_BANKS{w_ref_sel}};

  always_comb begin
    w_bank = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (w_cas_gnt[b] | w_act_gnt[b] | w_pre_gnt[b]) w_bank = BA_W'(b);
    end
  end

  always_comb begin
    w_ctl.cs_n = 2'b10;
    w_ctl.cmd  = CMD_NOP;
    w_ctl.addr = '0;
    w_ba       = '0;
    if (w_ref_sel) begin
      w_ctl.cmd = CMD_REF;
    end else if (w_cas_sel) begin
      w_ctl.cmd      = (|rd_gnt) ? CMD_RD : CMD_WR;
      w_ctl.addr     = DFI_ADDR_WIDTH'(ca[w_bank]);
      w_ctl.addr[10] = 1'b0;
      w_ba           = w_bank;
    end else if (w_act_sel) begin
      w_ctl.cmd  = CMD_ACT;
      w_ctl.addr = DFI_ADDR_WIDTH'(ra[w_bank]);
      w_ba       = w_bank;
    end else if (w_pre_sel) begin
      w_ctl.cmd  = CMD_PRE;
      w_ba       = w_bank;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cke <= 1'b0;
      r_ctl <= '{cs_n: 2'b11, cmd: CMD_NOP, addr: '0};
      r_ba  <= '0;
      r_rrd <= '0;
      r_ccd <= '0;
      r_wtr <= '0;
      r_rtw <= '0;
    end else begin
      r_cke <= 1'b1;
      r_ctl <= w_ctl;
      r_ba  <= w_ba;
      r_rrd <= w_act_sel   ? timer_load(t_rrd) : timer_dec(r_rrd);
      r_ccd <= w_cas_sel   ? timer_load(t_ccd) : timer_dec(r_ccd);
      r_wtr <= (|wr_gnt)   ? timer_load(t_wtr) : timer_dec(r_wtr);
      r_rtw <= (|rd_gnt)   ? timer_load(t_rtw) : timer_dec(r_rtw);
    end
  end

  assign cke                 = r_cke;
  assign cs_n                = r_ctl.cs_n;
  assign {ras_n, cas_n, we_n} = r_ctl.cmd;
  assign ba                  = r_ba;
  assign addr                = r_ctl.addr;

`ifdef SAL_CMD_SCHED_ODT_EN
  localparam int ODT_CNT_W = $clog2(ODT_LEN + 1);

  logic [ODT_CNT_W-1:0] r_odt_cnt;
  logic                 r_odt;

  // Held ODT_LEN cycles from the WR edge; a new WR reloads the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_odt_cnt <= '0;
      r_odt     <= 1'b0;
    end else if (|wr_gnt) begin
      r_odt_cnt <= ODT_CNT_W'(ODT_LEN - 1);
      r_odt     <= 1'b1;
    end else if (r_odt_cnt != '0) begin
      r_odt_cnt <= r_odt_cnt - 1'b1;
    end else begin
      r_odt     <= 1'b0;
    end
  end

  assign odt = r_odt;
`else
  assign odt = 1'b0;
`endif

endmodule
